// File: rtl/wfg_axis_arbiter.sv
// Grants one of NUM_SRC AXI-Stream sources to a shared driver in bursts; round-robin when WFG_AXIS_ARB_RR_EN is defined, fixed priority otherwise.
// One-cycle registered output; upstream ready follows output-register space, with one IDLE bubble between grants.
module wfg_axis_arbiter #(
    parameter int NUM_SRC         = 2,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int BURSTW          = 8,
    localparam int GW             = $clog2(NUM_SRC)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cfg_en_i,
    input  logic                                 cfg_mode_i,
    input  logic [NUM_SRC-1:0]                   cfg_mask_i,
    input  logic [BURSTW-1:0]                    cfg_burst_i,
    input  logic [NUM_SRC-1:0]                   s_axis_tvalid_i,
    input  logic [NUM_SRC*AXIS_DATA_WIDTH-1:0]   s_axis_tdata_i,
    output logic [NUM_SRC-1:0]                   s_axis_tready_o,
    output logic                                 m_axis_tvalid_o,
    output logic [AXIS_DATA_WIDTH-1:0]           m_axis_tdata_o,
    input  logic                                 m_axis_tready_i,
    output logic [GW-1:0]                        grant_o,
    output logic                                 busy_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]                 state_q, state_d;
    logic [GW-1:0]              grant_q, grant_d;
    logic [BURSTW-1:0]          cnt_q, cnt_d;
    logic [BURSTW-1:0]          burst_q, burst_d;
    logic                       m_vld_q, m_vld_d;
    logic [AXIS_DATA_WIDTH-1:0] m_dat_q, m_dat_d;

    logic [NUM_SRC-1:0]         req;
    logic [NUM_SRC-1:0]         rdy;
    logic [GW-1:0]              fp_win;
    logic [GW-1:0]              win;
    logic [BURSTW:0]            cnt_inc;
    logic                       out_free;
    logic                       abort;
    logic                       accept;
    logic                       sel_vld;
    logic [AXIS_DATA_WIDTH-1:0] sel_dat;

    assign req      = s_axis_tvalid_i & cfg_mask_i;
    assign out_free = !m_vld_q || m_axis_tready_i;
    assign abort    = !cfg_en_i || !cfg_mask_i[grant_q];
    assign sel_vld  = s_axis_tvalid_i[grant_q];
    assign sel_dat  = s_axis_tdata_i[int'(grant_q)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    assign cnt_inc  = {1'b0, cnt_q} + {{BURSTW{1'b0}}, 1'b1};

    always_comb begin
        fp_win = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) fp_win = GW'(i);
        end
    end

`ifdef WFG_AXIS_ARB_RR_EN
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] rr_win;

    // Lowest requester above the pointer; falls back to the lowest overall (wrap).
    always_comb begin
        rr_win = fp_win;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(rr_ptr_q))) rr_win = GW'(i);
        end
    end

    assign win = cfg_mode_i ? rr_win : fp_win;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == ST_IDLE && cfg_en_i && (|req) && cfg_mode_i) rr_ptr_d = rr_win;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= GW'(NUM_SRC - 1);
        else        rr_ptr_q <= rr_ptr_d;
    end
`else
    logic unused_mode;
    assign unused_mode = cfg_mode_i;
    assign win         = fp_win;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        rdy     = '0;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_en_i && (|req)) begin
                    state_d = ST_GRANT;
                    grant_d = win;
                    cnt_d   = '0;
                    burst_d = (cfg_burst_i == '0) ? {{(BURSTW-1){1'b0}}, 1'b1} : cfg_burst_i;
                end
            end
            default: begin
                // Disable or mask drop closes the grant in the same cycle, ready suppressed.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (out_free) begin
                    rdy[grant_q] = 1'b1;
                    if (sel_vld) begin
                        accept = 1'b1;
                        cnt_d  = cnt_inc[BURSTW-1:0];
                        if (cnt_inc == {1'b0, burst_q}) state_d = ST_IDLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        m_vld_d = m_vld_q;
        m_dat_d = m_dat_q;
        if (accept) begin
            m_vld_d = 1'b1;
            m_dat_d = sel_dat;
        end else if (m_axis_tready_i) begin
            m_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
            burst_q <= '0;
            m_vld_q <= 1'b0;
            m_dat_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            m_vld_q <= m_vld_d;
            m_dat_q <= m_dat_d;
        end
    end

    assign s_axis_tready_o = rdy;
    assign m_axis_tvalid_o = m_vld_q;
    assign m_axis_tdata_o  = m_dat_q;
    assign grant_o         = grant_q;
    assign busy_o          = (state_q == ST_GRANT);

endmodule

// File: tb/tb_wfg_axis_arbiter.sv
// Bench for wfg_axis_arbiter: directed scenarios plus randomized traffic against a beat-level reference model.
module tb_wfg_axis_arbiter;

    localparam int NS = 2;
    localparam int W  = 32;
    localparam int BW = 8;
    localparam int GW = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_en_i, cfg_mode_i;
    logic [NS-1:0]     cfg_mask_i;
    logic [BW-1:0]     cfg_burst_i;
    logic [NS-1:0]     s_axis_tvalid_i;
    logic [NS*W-1:0]   s_axis_tdata_i;
    logic [NS-1:0]     s_axis_tready_o;
    logic              m_axis_tvalid_o;
    logic [W-1:0]      m_axis_tdata_o;
    logic              m_axis_tready_i;
    logic [GW-1:0]     grant_o;
    logic              busy_o;

    always #5 clk = ~clk;

    wfg_axis_arbiter #(.NUM_SRC(NS), .AXIS_DATA_WIDTH(W), .BURSTW(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_en_i(cfg_en_i), .cfg_mode_i(cfg_mode_i), .cfg_mask_i(cfg_mask_i), .cfg_burst_i(cfg_burst_i),
        .s_axis_tvalid_i(s_axis_tvalid_i), .s_axis_tdata_i(s_axis_tdata_i), .s_axis_tready_o(s_axis_tready_o),
        .m_axis_tvalid_o(m_axis_tvalid_o), .m_axis_tdata_o(m_axis_tdata_o), .m_axis_tready_i(m_axis_tready_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    int checks = 0;
    int errors = 0;

    // Values applied at the next clock's negedge
    logic          nxt_en, nxt_mode, nxt_mrdy;
    logic [NS-1:0] nxt_mask;
    logic [BW-1:0] nxt_burst;

    int            src_ctl [NS];   // 0 idle, 1 stream up to src_lim, 2 random (AXIS hold rule)
    int            src_lim [NS];
    int            seq     [NS];
    logic [NS-1:0] hs_prev;

    // Reference model: who owns the driver, beats left in this grant, last RR winner, output slot
    bit            mb;
    int            msrc, mleft, mlast;
    bit            movld;
    logic [W-1:0]  modat;

    logic [NS-1:0] exp_rdy;
    bit            exp_busy, exp_mv;
    int            exp_grant;
    logic [W-1:0]  exp_md;

    function automatic logic [W-1:0] beat(input int k, input int s);
        logic [W-1:0] r;
        r = {k[3:0], s[27:0]};
        return r;
    endfunction

    task automatic model_reset();
        mb = 0; msrc = 0; mleft = 0; mlast = NS - 1; movld = 0; modat = '0;
    endtask

    task automatic model_eval();
        bit take;
        bit rr;
        int win;
        logic [NS-1:0] req;
        exp_busy = mb; exp_grant = msrc; exp_mv = movld; exp_md = modat; exp_rdy = '0;
        take = 0;
        req  = s_axis_tvalid_i & cfg_mask_i;
`ifdef WFG_AXIS_ARB_RR_EN
        rr = cfg_mode_i;
`else
        rr = 0;
`endif
        if (mb) begin
            if (!cfg_en_i || !cfg_mask_i[msrc]) begin
                mb = 0;
            end else if (!movld || m_axis_tready_i) begin
                exp_rdy[msrc] = 1'b1;
                if (s_axis_tvalid_i[msrc]) begin
                    take  = 1;
                    mleft = mleft - 1;
                    if (mleft == 0) mb = 0;
                end else begin
                    mb = 0;
                end
            end
        end else if (cfg_en_i && req != '0) begin
            win = -1;
            for (int i = 1; i <= NS; i++) begin
                int j;
                j = rr ? (mlast + i) % NS : i - 1;
                if (win < 0 && req[j]) win = j;
            end
            mb    = 1;
            msrc  = win;
            mleft = (cfg_burst_i == '0) ? 1 : int'(cfg_burst_i);
            if (rr) mlast = win;
        end
        if (take) begin
            movld = 1;
            modat = s_axis_tdata_i[exp_grant*W +: W];
        end else if (m_axis_tready_i) begin
            movld = 0;
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, advance the model
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < NS; k++) begin
            if (hs_prev[k]) seq[k]++;
            s_axis_tdata_i[k*W +: W] = beat(k, seq[k]);
            case (src_ctl[k])
                1:       s_axis_tvalid_i[k] = (seq[k] < src_lim[k]);
                2:       s_axis_tvalid_i[k] = (s_axis_tvalid_i[k] && !hs_prev[k]) ? 1'b1 : ($urandom_range(0, 2) != 0);
                default: s_axis_tvalid_i[k] = 1'b0;
            endcase
        end
        cfg_en_i = nxt_en; cfg_mode_i = nxt_mode; cfg_mask_i = nxt_mask;
        cfg_burst_i = nxt_burst; m_axis_tready_i = nxt_mrdy;
        #1;
        hs_prev = s_axis_tvalid_i & s_axis_tready_o;
        model_eval();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cfg_en_i = 0; cfg_mode_i = 0; cfg_mask_i = '0; cfg_burst_i = '0;
        s_axis_tvalid_i = '0; s_axis_tdata_i = '0; m_axis_tready_i = 0;
        nxt_en = 1; nxt_mode = 0; nxt_mask = '1; nxt_burst = '0; nxt_mrdy = 1;
        for (int k = 0; k < NS; k++) begin
            src_ctl[k] = 0; src_lim[k] = 1 << 30; seq[k] = 0;
        end
        hs_prev = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_en_i = 1; cfg_mask_i = '1; cfg_burst_i = 8'd4; s_axis_tvalid_i = '1; m_axis_tready_i = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (m_axis_tvalid_o !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b want 0", m_axis_tvalid_o); end
        checks++; if (m_axis_tdata_o !== '0) begin errors++; $display("FAIL reset_tdata: got %0h want 0", m_axis_tdata_o); end
        checks++; if (s_axis_tready_o !== '0) begin errors++; $display("FAIL reset_tready: got %0b want 0", s_axis_tready_o); end
        checks++; if (grant_o !== '0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
    endtask

    task automatic test_fixed_prio();
        do_reset();
        nxt_burst = 8'd4; src_ctl[0] = 1; src_ctl[1] = 1;
        for (int c = 0; c < 11; c++) begin
            step();
            checks++; if (grant_o !== 1'b0) begin errors++; $display("FAIL fp_grant c=%0d: got %0d want 0", c, grant_o); end
            if (c >= 2) begin
                checks++;
                if (m_axis_tvalid_o !== (c != 6)) begin errors++; $display("FAIL fp_tvalid c=%0d: got %0b want %0b", c, m_axis_tvalid_o, c != 6); end
                if (c != 6) begin
                    checks++;
                    if (m_axis_tdata_o !== beat(0, (c < 6) ? c - 2 : c - 3)) begin
                        errors++; $display("FAIL fp_tdata c=%0d: got %0h want %0h", c, m_axis_tdata_o, beat(0, (c < 6) ? c - 2 : c - 3));
                    end
                end
            end
        end
    endtask

`ifdef WFG_AXIS_ARB_RR_EN
    task automatic test_round_robin();
        int pat [8] = '{0, 0, -1, 1, 1, -1, 0, 0};
        int n   [NS];
        do_reset();
        nxt_mode = 1; nxt_burst = 8'd2; src_ctl[0] = 1; src_ctl[1] = 1;
        n[0] = 0; n[1] = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (c == 1 || c == 4 || c == 7) begin
                checks++;
                if (grant_o !== ((c == 4) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL rr_grant c=%0d: got %0d want %0d", c, grant_o, c == 4); end
            end
            if (c >= 2) begin
                checks++;
                if (m_axis_tvalid_o !== (pat[c-2] >= 0)) begin errors++; $display("FAIL rr_tvalid c=%0d: got %0b want %0b", c, m_axis_tvalid_o, pat[c-2] >= 0); end
                if (pat[c-2] >= 0) begin
                    checks++;
                    if (m_axis_tdata_o !== beat(pat[c-2], n[pat[c-2]])) begin
                        errors++; $display("FAIL rr_tdata c=%0d: got %0h want %0h", c, m_axis_tdata_o, beat(pat[c-2], n[pat[c-2]]));
                    end
                    n[pat[c-2]]++;
                end
            end
        end
    endtask
`endif

    task automatic test_backpressure();
        do_reset();
        nxt_burst = 8'd3; src_ctl[0] = 1;
        for (int c = 0; c < 11; c++) begin
            nxt_mrdy = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
            step();
            if (c >= 2 && c <= 6) begin
                checks++; if (m_axis_tvalid_o !== 1'b1) begin errors++; $display("FAIL bp_hold_vld c=%0d: got %0b want 1", c, m_axis_tvalid_o); end
                checks++; if (m_axis_tdata_o !== beat(0, 0)) begin errors++; $display("FAIL bp_hold_dat c=%0d: got %0h want %0h", c, m_axis_tdata_o, beat(0, 0)); end
                checks++; if (s_axis_tready_o !== 2'b00) begin errors++; $display("FAIL bp_tready c=%0d: got %0b want 00", c, s_axis_tready_o); end
            end
            if (c == 7) begin
                checks++; if (s_axis_tready_o !== 2'b01) begin errors++; $display("FAIL bp_resume: got %0b want 01", s_axis_tready_o); end
            end
            if (c == 8 || c == 9) begin
                checks++; if (m_axis_tdata_o !== beat(0, c - 7)) begin errors++; $display("FAIL bp_order c=%0d: got %0h want %0h", c, m_axis_tdata_o, beat(0, c - 7)); end
            end
            if (c == 10) begin
                checks++; if (m_axis_tvalid_o !== 1'b0) begin errors++; $display("FAIL bp_bubble: got %0b want 0", m_axis_tvalid_o); end
            end
        end
    endtask

    task automatic test_mask_enable();
        do_reset();
        nxt_burst = 8'd8; src_ctl[0] = 1; src_ctl[1] = 1;
        for (int c = 0; c < 11; c++) begin
            nxt_mask = (c >= 3) ? 2'b10 : 2'b11;
            nxt_en   = (c >= 6) ? 1'b0 : 1'b1;
            step();
            if (c == 2) begin
                checks++; if (s_axis_tready_o !== 2'b01) begin errors++; $display("FAIL me_pre: got %0b want 01", s_axis_tready_o); end
            end
            if (c == 3) begin
                checks++; if (s_axis_tready_o !== 2'b00) begin errors++; $display("FAIL me_mask_drop: got %0b want 00", s_axis_tready_o); end
            end
            if (c == 5) begin
                checks++; if (s_axis_tready_o !== 2'b10) begin errors++; $display("FAIL me_src1_rdy: got %0b want 10", s_axis_tready_o); end
                checks++; if (grant_o !== 1'b1) begin errors++; $display("FAIL me_src1_grant: got %0d want 1", grant_o); end
            end
            if (c >= 6) begin
                checks++; if (s_axis_tready_o !== 2'b00) begin errors++; $display("FAIL me_dis_rdy c=%0d: got %0b want 00", c, s_axis_tready_o); end
            end
            if (c >= 7) begin
                checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL me_dis_busy c=%0d: got %0b want 0", c, busy_o); end
            end
        end
    endtask

    task automatic test_source_stall();
        int beats = 0;
        do_reset();
        nxt_burst = 8'd8; src_ctl[1] = 1; src_lim[1] = 3;
        for (int c = 0; c < 13; c++) begin
            step();
            if (m_axis_tvalid_o === 1'b1) begin
                checks++;
                if (m_axis_tdata_o !== beat(1, beats)) begin errors++; $display("FAIL stall_dat c=%0d: got %0h want %0h", c, m_axis_tdata_o, beat(1, beats)); end
                beats++;
            end
            if (c == 4) begin
                checks++; if (busy_o !== 1'b1 || s_axis_tready_o !== 2'b10) begin
                    errors++; $display("FAIL stall_last: got busy=%0b rdy=%0b want busy=1 rdy=10", busy_o, s_axis_tready_o);
                end
            end
            if (c == 5) begin
                checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL stall_release: got %0b want 0", busy_o); end
            end
        end
        checks++; if (beats != 3) begin errors++; $display("FAIL stall_count: got %0d want 3", beats); end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        nxt_mode = 1; nxt_burst = 8'd4; src_ctl[0] = 1;
        for (int c = 0; c < 3; c++) step();
        rst_n = 1'b0;
        #1;
        checks++; if (m_axis_tvalid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_vld: got %0b want 0", m_axis_tvalid_o); end
        checks++; if (s_axis_tready_o !== 2'b00) begin errors++; $display("FAIL mid_rst_rdy: got %0b want 00", s_axis_tready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0b want 0", busy_o); end
        hs_prev = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        src_ctl[1] = 1;
        for (int c = 0; c < 2; c++) step();
        checks++; if (busy_o !== 1'b1 || grant_o !== 1'b0 || s_axis_tready_o !== 2'b01) begin
            errors++; $display("FAIL mid_rst_restart: got busy=%0b grant=%0d rdy=%0b want 1 0 01", busy_o, grant_o, s_axis_tready_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        src_ctl[0] = 2; src_ctl[1] = 2;
        nxt_burst = 8'd3;
        for (int c = 0; c < 4000; c++) begin
            nxt_mrdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) begin
                nxt_en    = ($urandom_range(0, 7) != 0);
                nxt_mask  = NS'($urandom_range(0, 3));
                nxt_burst = BW'($urandom_range(0, 5));
                nxt_mode  = ($urandom_range(0, 1) != 0);
            end
            step();
            checks++; if (s_axis_tready_o !== exp_rdy) begin errors++; $display("FAIL rnd_rdy c=%0d: got %0b want %0b", c, s_axis_tready_o, exp_rdy); end
            checks++; if (m_axis_tvalid_o !== exp_mv) begin errors++; $display("FAIL rnd_vld c=%0d: got %0b want %0b", c, m_axis_tvalid_o, exp_mv); end
            checks++; if (exp_mv && m_axis_tdata_o !== exp_md) begin errors++; $display("FAIL rnd_dat c=%0d: got %0h want %0h", c, m_axis_tdata_o, exp_md); end
            checks++; if (grant_o !== exp_grant[GW-1:0]) begin errors++; $display("FAIL rnd_grant c=%0d: got %0d want %0d", c, grant_o, exp_grant); end
            checks++; if (busy_o !== exp_busy) begin errors++; $display("FAIL rnd_busy c=%0d: got %0b want %0b", c, busy_o, exp_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_prio();
`ifdef WFG_AXIS_ARB_RR_EN
        test_round_robin();
`endif
        test_backpressure();
        test_mask_enable();
        test_source_stall();
        test_reset_midburst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
